ofm_result_checker: RTL and testbench
=====================================

# ofm_result_checker

Synthesisable on-chip scoreboard that streams the packed OFM RAM and a golden-reference RAM in lockstep, compares every DATA_WIDTH element (signed, optional tolerance) and reports pass/fail, mismatch count and first-failing element. Sits beside `TOP` on the OFM dual-port RAM read side. Replaces the simulation-only element-by-element compare loop, so self-checks run on FPGA and in gate-level sim. Handles any layer size, a partial last word, and either stop-on-first-error or count-all.

## Interface
- DATA_WIDTH, 16, element width (signed two's complement)
- INOUT_WIDTH, 256, RAM word width; LANES = INOUT_WIDTH/DATA_WIDTH elements per word
- ADDR_WIDTH, 20, word address width of both RAMs
- CNT_WIDTH, 24, element count / element address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, accepted only in IDLE or DONE
- num_elem  in  CNT_WIDTH  elements to check (e.g. 13*13*32 = 5408); sampled on start
- tolerance  in  DATA_WIDTH  unsigned max |ofm-gold| accepted; 0 = exact; sampled on start
- stop_on_err  in  1  1 = halt at first failing word; sampled on start
- ofm_rd_en / gold_rd_en  out  1  read strobes (always equal)
- ofm_rd_addr / gold_rd_addr  out  ADDR_WIDTH  word addresses (always equal)
- ofm_rd_data / gold_rd_data  in  INOUT_WIDTH  data, valid exactly 1 cycle after rd_en; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high from the cycle after start until done
- done  out  1  level, held until next accepted start
- pass  out  1  valid while done; 1 iff zero mismatches
- mismatch_count  out  CNT_WIDTH  failing elements, saturates at all-ones
- first_err_addr  out  CNT_WIDTH  element index of first mismatch (word*LANES+lane)
- first_err_ofm / first_err_gold  out  DATA_WIDTH  values at first mismatch

## Operation
- States: IDLE -> READ -> DRAIN -> DONE; DONE -> READ on start; any -> IDLE on reset.
- Accepted start: latch config, clear count/first_err/pass, num_words = ceil(num_elem/LANES), word pointer = 0. num_elem = 0 -> go straight to DRAIN (no reads).
- READ: rd_en=1, addr=pointer, pointer++ each cycle; after addr = num_words-1 -> DRAIN.
- Compare stage (cycle after each rd_en): lane k valid iff word*LANES+k < num_elem; fail iff valid and |ofm-gold| > tolerance, difference in DATA_WIDTH+1 bits, signed.
- Per failing word: mismatch_count += popcount(fail vector), saturating; if no error yet recorded, capture lowest failing lane's address and values.
- stop_on_err=1 and a word fails: READ stops immediately (in-flight read's data discarded), go to DRAIN.
- DRAIN: one cycle to retire last compare -> DONE; pass = (count == 0).
- start while busy is ignored.

## Timing
- Reset: state IDLE, rd_en 0, addresses 0, busy 0, done 0, pass 0, count 0, first_err_* 0.
- start sampled at edge 0: rd_en high cycles 1..N (N = num_words); compare of word w in cycle w+2; done=1 and busy=0 from cycle N+2.
- Early stop: failing word's data seen in cycle c -> rd_en low from cycle c+1, done from cycle c+2.
- num_elem = 0: done from cycle 2, pass=1.
- Reset mid-run: all outputs return to reset values asynchronously; no further reads.

## Structure
- Package `ofm_checker_pkg`: LANES localparam function, state enum (IDLE, READ, DRAIN, DONE), abs-diff width constant.
- Sub-module `ofm_lane_cmp` (combinational, one per lane via generate): valid, a, b, tolerance -> fail. Top holds FSM, pointers, popcount, priority encoder, result registers.

## Test plan
- Exact match, num_elem=5408, LANES=16 -> 338 reads, done at cycle 340, pass=1, count=0.
- Single corruption at element 1000 (gold=7, ofm=8), tol=0, count-all -> pass=0, count=1, first_err_addr=1000, ofm=8, gold=7.
- Same corruption, tol=1 -> pass=1; ofm=-5 vs gold=5, tol=9 -> fail (diff 10).
- Errors at 40 and 41, stop_on_err=1 -> reads stop after word 3, count=2, first_err_addr=40, done 2 cycles after word-2 data.
- num_elem=17: lanes 1..15 of word 1 hold garbage -> ignored, pass=1, 2 reads; num_elem=0 -> no reads, done at cycle 2, pass=1.
- rst_n low mid-READ -> outputs zero immediately; restart with start -> clean full run with correct results.

Source files
------------

// File: rtl/ofm_result_checker_pkg.sv
// Shared types and helpers for the OFM result checker: lane count,
// FSM state encoding and the width used for signed element differences.
package ofm_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One extra bit keeps a - b of two DATA_WIDTH signed values from overflowing.
  localparam int ABS_DIFF_EXTRA = 1;

  // Number of elements packed into one RAM word.
  function automatic int lanes_f(input int inout_w, input int data_w);
    return inout_w / data_w;
  endfunction

  // Width of the signed difference and of its magnitude.
  function automatic int abs_diff_w_f(input int data_w);
    return data_w + ABS_DIFF_EXTRA;
  endfunction

endpackage

// File: rtl/ofm_result_checker_if.sv
// Read bus towards the OFM RAM and the golden RAM. Both are read in lockstep,
// so the checker drives identical strobes and addresses on the two ports.
interface ofm_result_checker_if #(
  parameter int INOUT_WIDTH = 256,
  parameter int ADDR_WIDTH  = 20
) ();

  logic                   ofm_rd_en;
  logic [ADDR_WIDTH-1:0]  ofm_rd_addr;
  logic [INOUT_WIDTH-1:0] ofm_rd_data;
  logic                   gold_rd_en;
  logic [ADDR_WIDTH-1:0]  gold_rd_addr;
  logic [INOUT_WIDTH-1:0] gold_rd_data;

  // Checker side: issues reads, receives data one cycle later.
  modport master (
    output ofm_rd_en, ofm_rd_addr, gold_rd_en, gold_rd_addr,
    input  ofm_rd_data, gold_rd_data
  );

  // RAM side: accepts reads, returns data.
  modport slave (
    input  ofm_rd_en, ofm_rd_addr, gold_rd_en, gold_rd_addr,
    output ofm_rd_data, gold_rd_data
  );

endinterface

// File: rtl/ofm_result_checker_lane_cmp.sv
// Single-lane element comparator: flags a valid lane whose signed
// difference magnitude exceeds the unsigned tolerance.
module ofm_lane_cmp
  import ofm_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] tolerance,
  output logic                  fail
);

  localparam int DW = abs_diff_w_f(DATA_WIDTH);

  logic signed [DW-1:0] diff_s;
  logic        [DW-1:0] mag_s;

  // Sign-extend both operands, take |a-b| and test it against the tolerance.
  always_comb begin
    diff_s = $signed({a[DATA_WIDTH-1], a}) - $signed({b[DATA_WIDTH-1], b});
    if (diff_s < $signed({DW{1'b0}})) begin
      mag_s = $unsigned(-diff_s);
    end else begin
      mag_s = $unsigned(diff_s);
    end
    if (valid && (mag_s > {1'b0, tolerance})) begin
      fail = 1'b1;
    end else begin
      fail = 1'b0;
    end
  end

endmodule

// File: rtl/ofm_result_checker.sv
// On-chip scoreboard: streams the OFM RAM and the golden RAM word by word,
// compares every element with an optional tolerance and reports pass/fail,
// the number of failing elements and the first failing element.
module ofm_result_checker
  import ofm_checker_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int INOUT_WIDTH = 256,
  parameter int ADDR_WIDTH  = 20,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_elem,
  input  logic [DATA_WIDTH-1:0]   tolerance,
  input  logic                    stop_on_err,
  ofm_result_checker_if.master    rd_bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_WIDTH-1:0]    mismatch_count,
  output logic [CNT_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]   first_err_ofm,
  output logic [DATA_WIDTH-1:0]   first_err_gold
);

  localparam int LANES   = lanes_f(INOUT_WIDTH, DATA_WIDTH);
  localparam int LANE_SH = $clog2(LANES);
  localparam int LANE_W  = (LANES > 1) ? LANE_SH : 1;
  localparam int IDX_W   = CNT_WIDTH + ADDR_WIDTH;
  localparam int NW_W    = CNT_WIDTH + 1;

  // Control and configuration registers
  state_e                  state_r;
  logic                    rd_en_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic                    cmp_vld_r;
  logic [ADDR_WIDTH-1:0]   cmp_word_r;
  logic [CNT_WIDTH-1:0]    num_elem_r;
  logic [DATA_WIDTH-1:0]   tol_r;
  logic                    stop_r;
  logic [NW_W-1:0]         num_words_r;

  // Result registers
  logic                    busy_r;
  logic                    done_r;
  logic                    pass_r;
  logic [CNT_WIDTH-1:0]    count_r;
  logic [CNT_WIDTH-1:0]    first_addr_r;
  logic [DATA_WIDTH-1:0]   first_ofm_r;
  logic [DATA_WIDTH-1:0]   first_gold_r;

  // Compare-stage signals
  logic [IDX_W-1:0]        base_s;
  logic [IDX_W-1:0]        num_elem_ext_s;
  logic [LANES-1:0]        lane_vld_s;
  logic [LANES-1:0]        fail_vec_s;
  logic [LANE_W:0]         pop_s;
  logic [LANE_W-1:0]       first_lane_s;
  logic                    any_fail_s;
  logic [NW_W-1:0]         sum_s;
  logic [CNT_WIDTH-1:0]    cnt_next_s;
  logic [IDX_W-1:0]        first_idx_s;
  logic [DATA_WIDTH-1:0]   sel_ofm_s;
  logic [DATA_WIDTH-1:0]   sel_gold_s;
  logic                    last_word_s;
  logic [NW_W-1:0]         start_nw_s;

  assign base_s         = IDX_W'(cmp_word_r) << LANE_SH;
  assign num_elem_ext_s = IDX_W'(num_elem_r);

  // One comparator per lane; lanes past num_elem (partial last word) never fail.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IDX_W-1:0] idx_s;
    assign idx_s         = base_s + IDX_W'(k);
    assign lane_vld_s[k] = cmp_vld_r && (idx_s < num_elem_ext_s);

    ofm_lane_cmp #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
      .valid     (lane_vld_s[k]),
      .a         (rd_bus.ofm_rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .b         (rd_bus.gold_rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .tolerance (tol_r),
      .fail      (fail_vec_s[k])
    );
  end

  // Popcount of the fail vector and lowest failing lane (scan high to low).
  always_comb begin
    pop_s        = '0;
    first_lane_s = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (fail_vec_s[k]) begin
        pop_s        = pop_s + (LANE_W + 1)'(1);
        first_lane_s = LANE_W'(k);
      end else begin
        pop_s        = pop_s;
      end
    end
  end

  // Saturating count update, first-error data selection and word bookkeeping.
  always_comb begin
    any_fail_s  = |fail_vec_s;
    sum_s       = {1'b0, count_r} + NW_W'(pop_s);
    if (sum_s[CNT_WIDTH]) begin
      cnt_next_s = '1;
    end else begin
      cnt_next_s = sum_s[CNT_WIDTH-1:0];
    end
    first_idx_s = base_s + IDX_W'(first_lane_s);
    sel_ofm_s   = rd_bus.ofm_rd_data[first_lane_s*DATA_WIDTH +: DATA_WIDTH];
    sel_gold_s  = rd_bus.gold_rd_data[first_lane_s*DATA_WIDTH +: DATA_WIDTH];
    last_word_s = ((NW_W'(rd_addr_r) + NW_W'(1)) == num_words_r);
    start_nw_s  = ({1'b0, num_elem} + NW_W'(LANES - 1)) >> LANE_SH;
  end

  // Checker FSM: issues reads, retires compares one cycle later, publishes results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rd_en_r      <= 1'b0;
      rd_addr_r    <= '0;
      cmp_vld_r    <= 1'b0;
      cmp_word_r   <= '0;
      num_elem_r   <= '0;
      tol_r        <= '0;
      stop_r       <= 1'b0;
      num_words_r  <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      count_r      <= '0;
      first_addr_r <= '0;
      first_ofm_r  <= '0;
      first_gold_r <= '0;
    end else begin
      cmp_vld_r <= 1'b0;
      if (any_fail_s) begin
        count_r <= cnt_next_s;
        if (count_r == '0) begin
          first_addr_r <= first_idx_s[CNT_WIDTH-1:0];
          first_ofm_r  <= sel_ofm_s;
          first_gold_r <= sel_gold_s;
        end
      end
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            num_elem_r   <= num_elem;
            tol_r        <= tolerance;
            stop_r       <= stop_on_err;
            num_words_r  <= start_nw_s;
            rd_addr_r    <= '0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            count_r      <= '0;
            first_addr_r <= '0;
            first_ofm_r  <= '0;
            first_gold_r <= '0;
            if (num_elem == '0) begin
              rd_en_r <= 1'b0;
              state_r <= DRAIN;
            end else begin
              rd_en_r <= 1'b1;
              state_r <= READ;
            end
          end
        end
        READ: begin
          // Data for the word presented last cycle is on the bus now.
          cmp_vld_r  <= 1'b1;
          cmp_word_r <= rd_addr_r;
          if (any_fail_s && stop_r) begin
            // The read issued this cycle is in flight; its data is dropped.
            rd_en_r   <= 1'b0;
            cmp_vld_r <= 1'b0;
            state_r   <= DRAIN;
          end else if (last_word_s) begin
            rd_en_r <= 1'b0;
            state_r <= DRAIN;
          end else begin
            rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          pass_r  <= (cnt_next_s == '0);
          state_r <= DONE;
        end
        default: begin
          rd_en_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rd_bus.ofm_rd_en    = rd_en_r;
  assign rd_bus.gold_rd_en   = rd_en_r;
  assign rd_bus.ofm_rd_addr  = rd_addr_r;
  assign rd_bus.gold_rd_addr = rd_addr_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign pass                = pass_r;
  assign mismatch_count      = count_r;
  assign first_err_addr      = first_addr_r;
  assign first_err_ofm       = first_ofm_r;
  assign first_err_gold      = first_gold_r;

endmodule

// File: tb/tb_ofm_result_checker.sv
// Scoreboard bench for ofm_result_checker: element-level reference model,
// RAM models with one-cycle read latency and a decoupled result monitor.
module tb_ofm_result_checker;

  localparam int DW    = 16;
  localparam int IW    = 256;
  localparam int AW    = 20;
  localparam int CW    = 24;
  localparam int LANES = 16;
  localparam int MAXW  = 512;
  localparam int NELEM = LANES * MAXW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop_on_err = 1'b0;
  logic [CW-1:0] num_elem = '0;
  logic [DW-1:0] tolerance = '0;
  logic          busy, done, pass;
  logic [CW-1:0] mismatch_count, first_err_addr;
  logic [DW-1:0] first_err_ofm, first_err_gold;

  ofm_result_checker_if #(.INOUT_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  ofm_result_checker #(
    .DATA_WIDTH(DW), .INOUT_WIDTH(IW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_elem       (num_elem),
    .tolerance      (tolerance),
    .stop_on_err    (stop_on_err),
    .rd_bus         (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .first_err_addr (first_err_addr),
    .first_err_ofm  (first_err_ofm),
    .first_err_gold (first_err_gold)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pass_v;
    int count;
    int faddr;
    int fofm;
    int fgold;
    int reads;
    int done_cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            ofm_e [NELEM];
  int            gold_e[NELEM];
  logic [IW-1:0] ofm_mem [MAXW];
  logic [IW-1:0] gold_mem[MAXW];
  bit            arm_req = 1'b0;
  int            runs_done = 0;
  bit            mon_armed = 1'b0;
  int            mon_rel = 0;
  int            mon_reads = 0;
  int            mon_bad = 0;
  exp_t          mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    return int'($signed(v));
  endfunction

  // RAM models: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (bus.ofm_rd_en) bus.ofm_rd_data <= ofm_mem[bus.ofm_rd_addr[8:0]];
    else               bus.ofm_rd_data <= {8{$urandom}};
    if (bus.gold_rd_en) bus.gold_rd_data <= gold_mem[bus.gold_rd_addr[8:0]];
    else                bus.gold_rd_data <= {8{$urandom}};
  end

  // Fresh data set: matching elements below ne, unrelated garbage above.
  task automatic fill(input int ne);
    for (int i = 0; i < NELEM; i++) begin
      gold_e[i] = rnd16();
      ofm_e[i]  = (i < ne) ? gold_e[i] : rnd16();
    end
  endtask

  task automatic pack();
    for (int w = 0; w < MAXW; w++) begin
      for (int k = 0; k < LANES; k++) begin
        ofm_mem[w][k*DW +: DW]  = 16'(ofm_e[w*LANES+k]);
        gold_mem[w][k*DW +: DW] = 16'(gold_e[w*LANES+k]);
      end
    end
  endtask

  // Reference: element-by-element compare, then derive reads and done timing.
  function automatic exp_t model(input int ne, input int tol, input bit soe);
    exp_t e;
    int   nw;
    int   fw;
    int   d;
    e  = '{1, 0, 0, 0, 0, 0, 0};
    nw = (ne + LANES - 1) / LANES;
    fw = -1;
    for (int i = 0; i < ne; i++) begin
      d = ofm_e[i] - gold_e[i];
      if (d < 0) d = -d;
      if (d > tol) begin
        if (fw < 0) begin
          e.faddr = i;
          e.fofm  = ofm_e[i];
          e.fgold = gold_e[i];
          fw      = i / LANES;
        end
        if (!soe || (i / LANES) == fw) e.count++;
      end
    end
    e.pass_v = (e.count == 0) ? 1 : 0;
    if (soe && fw >= 0) begin
      e.reads    = (fw + 2 < nw) ? fw + 2 : nw;
      e.done_cyc = (fw + 4 < nw + 2) ? fw + 4 : nw + 2;
    end else begin
      e.reads    = nw;
      e.done_cyc = nw + 2;
    end
    return e;
  endfunction

  task automatic launch(input int ne, input int tol, input bit soe, input bit arm);
    pack();
    if (arm) exp_q.push_back(model(ne, tol, soe));
    @(posedge clk); #2;
    num_elem    = CW'(ne);
    tolerance   = DW'(tol);
    stop_on_err = soe;
    start       = 1'b1;
    arm_req     = arm;
    @(posedge clk); #2;
    start       = 1'b0;
    arm_req     = 1'b0;
    num_elem    = CW'($urandom);
    tolerance   = DW'($urandom);
    stop_on_err = 1'($urandom);
  endtask

  task automatic wait_runs(input int target);
    int budget = 0;
    while (runs_done < target && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    if (runs_done < target) chk("run_complete", runs_done, target);
  endtask

  // Monitor: arms on a tracked start, counts reads, checks results at done.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_armed) begin
        mon_rel++;
        if (bus.ofm_rd_en || bus.gold_rd_en) begin
          if (bus.ofm_rd_en !== bus.gold_rd_en || bus.ofm_rd_addr !== bus.gold_rd_addr ||
              bus.ofm_rd_addr !== AW'(mon_reads)) mon_bad++;
          mon_reads++;
        end
        if (mon_rel == 1) chk("busy_after_start", busy, 1);
        if (done) begin
          chk("done_cycle", mon_rel, mon_e.done_cyc);
          chk("rd_count", mon_reads, mon_e.reads);
          chk("rd_addr_seq", mon_bad, 0);
          chk("busy_at_done", busy, 0);
          chk("pass", pass, mon_e.pass_v);
          chk("mismatch_count", mismatch_count, mon_e.count);
          chk("first_err_addr", first_err_addr, mon_e.faddr);
          chk("first_err_ofm", $signed(first_err_ofm), mon_e.fofm);
          chk("first_err_gold", $signed(first_err_gold), mon_e.fgold);
          mon_armed = 1'b0;
          runs_done++;
        end else if (mon_rel > 4000) begin
          chk("done_timeout", mon_rel, mon_e.done_cyc);
          mon_armed = 1'b0;
          runs_done++;
        end
      end else if (start && arm_req) begin
        if (exp_q.size() > 0) begin
          mon_e     = exp_q.pop_front();
          mon_armed = 1'b1;
          mon_rel   = 0;
          mon_reads = 0;
          mon_bad   = 0;
        end else begin
          chk("scoreboard_empty", 0, 1);
        end
      end
    end
  end

  initial begin
    int issued = 0;
    int ne, nerr, idx, tol, soe, idle_rd;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_en", bus.ofm_rd_en, 0);
    chk("reset_rd_addr", bus.ofm_rd_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_count", mismatch_count, 0);
    chk("reset_first_addr", first_err_addr, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Exact match over a full 13x13x32 layer
    fill(5408); launch(5408, 0, 0, 1); issued++; wait_runs(issued);
    // Single corruption, exact compare
    fill(5408); ofm_e[1000] = 8; gold_e[1000] = 7;
    launch(5408, 0, 0, 1); issued++; wait_runs(issued);
    // Same corruption within tolerance
    launch(5408, 1, 0, 1); issued++; wait_runs(issued);
    // Sign crossing: diff 10 against tolerance 9
    fill(5408); ofm_e[1000] = -5; gold_e[1000] = 5;
    launch(5408, 9, 0, 1); issued++; wait_runs(issued);
    // Two errors in word 2, stop on first failing word; later error ignored
    fill(5408); gold_e[40] = 100; ofm_e[40] = 101; gold_e[41] = -3; ofm_e[41] = 50;
    gold_e[2000] = 0; ofm_e[2000] = 9;
    launch(5408, 0, 1, 1); issued++; wait_runs(issued);
    // Partial last word with garbage lanes
    fill(17); launch(17, 0, 0, 1); issued++; wait_runs(issued);
    // Empty layer
    fill(0); launch(0, 0, 0, 1); issued++; wait_runs(issued);
    // Start while busy must be ignored
    fill(800); gold_e[300] = 1; ofm_e[300] = 4; gold_e[799] = -9; ofm_e[799] = 9;
    launch(800, 2, 0, 1); issued++;
    repeat (10) @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_runs(issued);

    // Reset in the middle of a read burst
    fill(5408); launch(5408, 0, 0, 0);
    repeat (40) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", bus.ofm_rd_en, 0);
    chk("midrst_rd_addr", bus.ofm_rd_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    idle_rd = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ofm_rd_en || bus.gold_rd_en) idle_rd++;
    end
    chk("midrst_no_reads", idle_rd, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    fill(5408); ofm_e[4321] = gold_e[4321] ^ 1;
    launch(5408, 0, 0, 1); issued++; wait_runs(issued);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      ne   = int'($urandom_range(0, 3000));
      tol  = int'($urandom_range(0, 6));
      soe  = int'($urandom_range(0, 1));
      nerr = int'($urandom_range(0, 4));
      fill(ne);
      if (ne > 0) begin
        for (int j = 0; j < nerr; j++) begin
          idx = int'($urandom_range(0, ne - 1));
          gold_e[idx] = rnd16() / 2;
          if ($urandom_range(0, 3) == 0) ofm_e[idx] = rnd16();
          else ofm_e[idx] = gold_e[idx] + int'($urandom_range(0, 16)) - 8;
        end
      end
      launch(ne, tol, soe[0], 1); issued++; wait_runs(issued);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
